// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/opcode widths, legal opcodes, loader FSM states.
// Latency: n/a (types and constants only).  Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 6;

    localparam logic [OP_W_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W_DEF-1:0] OP_SRL = 6'b000010;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        READY   = 2'd3
    } loader_state_e;

    function automatic logic is_legal_op(input logic [OP_W_DEF-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_legal_op = 1'b1;
            default:                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_input_loader_btn_conditioner.sv
// Button conditioner: 2-flop sync, optional debounce (ALU_LOADER_DEBOUNCE_EN), rising-edge pulse.
// Latency: pulse 2 edges after raw rises (+DEBOUNCE_CYCLES when debounced).  Backpressure: none.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    logic [1:0] sync_q;
    logic       level;
    logic       level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;

    // Any sample equal to the accepted level restarts the run of new-level samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (sync_q[1] == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q    <= '0;
            stable_q <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign level = stable_q;
`else
    assign level = sync_q[1];

    if (DEBOUNCE_CYCLES < 0) begin : g_no_debounce
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/alu_input_loader.sv
// Loads num1, num2, opcode from switches on button presses; ALU_LOADER_DEBOUNCE_EN adds debounce.
// Latency: outputs update 3 edges after btn_load rises (+DEBOUNCE_CYCLES if debounced).  Backpressure: none.
module alu_input_loader
    import alu_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int OP_W            = OP_W_DEF,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_load,
    input  logic              btn_clear,
    output logic [DATA_W-1:0] num1,
    output logic [DATA_W-1:0] num2,
    output logic [OP_W-1:0]   opcode,
    output logic              valid,
    output logic              op_err,
    output logic [1:0]        state
);

    logic          load_evt;
    logic          clear_evt;
    loader_state_e state_q;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_load (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_load),
        .pulse (load_evt)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_clear),
        .pulse (clear_evt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num1    <= '0;
            num2    <= '0;
            opcode  <= '0;
            valid   <= 1'b0;
            op_err  <= 1'b0;
            state_q <= LOAD_A;
        end else begin
            op_err <= 1'b0;
            // Clear wins over a load event arriving on the same edge.
            if (clear_evt) begin
                num1    <= '0;
                num2    <= '0;
                opcode  <= '0;
                valid   <= 1'b0;
                state_q <= LOAD_A;
            end else if (load_evt) begin
                case (state_q)
                    LOAD_A: begin
                        num1    <= sw;
                        state_q <= LOAD_B;
                    end
                    LOAD_B: begin
                        num2    <= sw;
                        state_q <= LOAD_OP;
                    end
                    LOAD_OP: begin
                        if (is_legal_op(sw[OP_W-1:0])) begin
                            opcode  <= sw[OP_W-1:0];
                            valid   <= 1'b1;
                            state_q <= READY;
                        end else begin
                            op_err <= 1'b1;
                        end
                    end
                    READY: begin
                        num1    <= sw;
                        valid   <= 1'b0;
                        state_q <= LOAD_B;
                    end
                    default: begin
                        valid   <= 1'b0;
                        state_q <= LOAD_A;
                    end
                endcase
            end
        end
    end

    assign state = state_q;

endmodule
